// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// flag_unit : architectural NZCV flag register with shadow stack for exceptions
// Revision  : 1.0
// ============================================================================
module flag_unit #(
   parameter int DEPTH = 2,
   parameter int PTRW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      ALUFlags,
   input  logic [1:0]      FlagW,
   input  logic            CondEx,
   input  logic            Stall,
   input  logic            ExcEntry,
   input  logic            ExcReturn,
   output logic [3:0]      Flags,
   output logic [3:0]      SavedFlags,
   output logic [PTRW-1:0] Depth,
   output logic            FlagsUpdated,
   output logic            StackErr
);

   logic [3:0]      flags_q, flags_d;
   logic [3:0]      stack_q [DEPTH];
   logic [3:0]      stack_d [DEPTH];
   logic [PTRW-1:0] depth_q, depth_d;
   logic [3:0]      saved_q, saved_d;
   logic            upd_q, upd_d;
   logic            err_q, err_d;

   logic            w_wr_nz;
   logic            w_wr_cv;
   logic [PTRW-1:0] w_top_idx;
   logic [PTRW-1:0] w_next_top_idx;
   logic            w_full;
   logic            w_empty;

   assign w_wr_nz        = FlagW[1] & CondEx;
   assign w_wr_cv        = FlagW[0] & CondEx;
   assign w_top_idx      = depth_q - PTRW'(1);
   assign w_next_top_idx = depth_d - PTRW'(1);
   assign w_full         = (depth_q == PTRW'(DEPTH));
   assign w_empty        = (depth_q == '0);

   always_comb begin
      flags_d = flags_q;
      stack_d = stack_q;
      depth_d = depth_q;
      err_d   = err_q;

      if (!Stall) begin
         if (ExcReturn && ExcEntry) begin
            err_d = 1'b1;
         end else if (ExcReturn) begin
            if (w_empty) begin
               err_d = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (PTRW'(i) == w_top_idx) begin
                     flags_d    = stack_q[i];
                     stack_d[i] = 4'b0000;
                  end
               end
               depth_d = depth_q - PTRW'(1);
            end
         end else if (ExcEntry) begin
            // The pushed value is the pre-update Flags; ALU writes are dropped.
            if (w_full) begin
               err_d = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (PTRW'(i) == depth_q) begin
                     stack_d[i] = flags_q;
                  end
               end
               depth_d = depth_q + PTRW'(1);
            end
         end else begin
            if (w_wr_nz) flags_d[3:2] = ALUFlags[3:2];
            if (w_wr_cv) flags_d[1:0] = ALUFlags[1:0];
         end
      end
   end

   // Top-of-stack view is computed from next state so it moves with the push/pop.
   always_comb begin
      saved_d = 4'b0000;
      if (depth_d != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (PTRW'(i) == w_next_top_idx) begin
               saved_d = stack_d[i];
            end
         end
      end
   end

   always_comb begin
      upd_d = 1'b0;
      if (!Stall) begin
         upd_d = (flags_d != flags_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= 4'b0000;
         depth_q <= '0;
         saved_q <= 4'b0000;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= 4'b0000;
         end
      end else begin
         flags_q <= flags_d;
         depth_q <= depth_d;
         saved_q <= saved_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign Flags        = flags_q;
   assign SavedFlags   = saved_q;
   assign Depth        = depth_q;
   assign FlagsUpdated = upd_q;
   assign StackErr     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// tb_flag_unit : directed + randomized checks of flag_unit against a queue model
// Revision     : 1.0
// ============================================================================
module tb_flag_unit;

   localparam int DEPTH = 2;
   localparam int PTRW  = $clog2(DEPTH + 1);

   logic            clk;
   logic            reset;
   logic [3:0]      ALUFlags;
   logic [1:0]      FlagW;
   logic            CondEx;
   logic            Stall;
   logic            ExcEntry;
   logic            ExcReturn;
   logic [3:0]      Flags;
   logic [3:0]      SavedFlags;
   logic [PTRW-1:0] Depth;
   logic            FlagsUpdated;
   logic            StackErr;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic [3:0] m_flags;
   logic [3:0] m_stack [$];
   logic       m_upd;
   logic       m_err;

   flag_unit #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
      .clk          (clk),
      .reset        (reset),
      .ALUFlags     (ALUFlags),
      .FlagW        (FlagW),
      .CondEx       (CondEx),
      .Stall        (Stall),
      .ExcEntry     (ExcEntry),
      .ExcReturn    (ExcReturn),
      .Flags        (Flags),
      .SavedFlags   (SavedFlags),
      .Depth        (Depth),
      .FlagsUpdated (FlagsUpdated),
      .StackErr     (StackErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_flags = 4'b0000;
      m_stack.delete();
      m_upd   = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [3:0] exp_saved;
      exp_saved = (m_stack.size() == 0) ? 4'b0000 : m_stack[m_stack.size()-1];
      check({tag, ".Flags"},        {4'b0, Flags},        {4'b0, m_flags});
      check({tag, ".SavedFlags"},   {4'b0, SavedFlags},   {4'b0, exp_saved});
      check({tag, ".Depth"},        8'(Depth),            8'(m_stack.size()));
      check({tag, ".FlagsUpdated"}, {7'b0, FlagsUpdated}, {7'b0, m_upd});
      check({tag, ".StackErr"},     {7'b0, StackErr},     {7'b0, m_err});
   endtask

   // Called at a negedge: drive, clock once, update model, compare at next negedge.
   task automatic cycle(input string tag, input logic [3:0] alu, input logic [1:0] fw,
                        input logic cex, input logic st, input logic en, input logic ret);
      logic [3:0] nf;
      ALUFlags  = alu;
      FlagW     = fw;
      CondEx    = cex;
      Stall     = st;
      ExcEntry  = en;
      ExcReturn = ret;
      @(posedge clk);
      nf = m_flags;
      if (st) begin
         m_upd = 1'b0;
      end else begin
         if (en && ret) begin
            m_err = 1'b1;
         end else if (ret) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else                    m_err = 1'b1;
         end else if (en) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else                        m_err = 1'b1;
         end else if (cex) begin
            if (fw[1]) nf[3:2] = alu[3:2];
            if (fw[0]) nf[1:0] = alu[1:0];
         end
         m_upd   = (nf != m_flags);
         m_flags = nf;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   // Reset asserted away from any clock edge; outputs must clear immediately.
   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      check({tag, ".rst_Flags"}, {4'b0, Flags},      8'h00);
      check({tag, ".rst_Saved"}, {4'b0, SavedFlags}, 8'h00);
      check({tag, ".rst_Depth"}, 8'(Depth),          8'h00);
      check({tag, ".rst_Upd"},   {7'b0, FlagsUpdated}, 8'h00);
      check({tag, ".rst_Err"},   {7'b0, StackErr},   8'h00);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; ALUFlags = '0; FlagW = '0; CondEx = 1'b0;
      Stall = 1'b0; ExcEntry = 1'b0; ExcReturn = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      cycle("idle", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("idle.Flags", {4'b0, Flags}, 8'h00);

      cycle("wr_nz", 4'b1011, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wr_nz.Flags", {4'b0, Flags}, 8'b1000);
      check("wr_nz.Upd", {7'b0, FlagsUpdated}, 8'h01);
      cycle("wr_cv", 4'b0111, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      check("wr_cv.Flags", {4'b0, Flags}, 8'b1011);
      cycle("gated", 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gated.Flags", {4'b0, Flags}, 8'b1011);
      check("gated.Upd", {7'b0, FlagsUpdated}, 8'h00);

      cycle("push1", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("push1.Saved", {4'b0, SavedFlags}, 8'b1011);
      cycle("wr0100", 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("push2", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("push2.Depth", 8'(Depth), 8'd2);
      check("push2.Saved", {4'b0, SavedFlags}, 8'b0100);
      cycle("wr0001", 4'b0001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("pop1", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pop1.Flags", {4'b0, Flags}, 8'b0100);
      cycle("pop2", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pop2.Flags", {4'b0, Flags}, 8'b1011);
      check("pop2.Saved", {4'b0, SavedFlags}, 8'h00);

      cycle("fill1", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("fill2", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("over", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("over.Depth", 8'(Depth), 8'd2);
      check("over.Err", {7'b0, StackErr}, 8'h01);

      async_reset("r1");
      cycle("under", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      check("under.Err", {7'b0, StackErr}, 8'h01);
      cycle("sticky", 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sticky.Err", {7'b0, StackErr}, 8'h01);

      async_reset("r2");
      cycle("wr0010", 4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("push_wr", 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      check("push_wr.Flags", {4'b0, Flags}, 8'b0010);
      check("push_wr.Saved", {4'b0, SavedFlags}, 8'b0010);
      cycle("both", 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      check("both.Err", {7'b0, StackErr}, 8'h01);
      check("both.Depth", 8'(Depth), 8'd1);

      for (int k = 0; k < 3; k++)
         cycle("stall", 4'b1101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      check("stall.Flags", {4'b0, Flags}, 8'b0010);

      async_reset("r3");
      cycle("wr1111", 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("push_f", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("push_f.Depth", 8'(Depth), 8'd1);
      async_reset("r4");

      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rnd_rst");
         end else begin
            cycle("rnd",
                  4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 6) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
